// File: rtl/decoder.sv
// Control decoder for a single-cycle ARM-subset datapath: decodes Op/Funct/Rd
// combinationally and registers every control output (one cycle of latency).
module decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  logic [1:0] reg_src_d;
  logic [1:0] imm_src_d;
  logic       alu_src_d;
  logic       mem_to_reg_d;
  logic       reg_w_d;
  logic       mem_w_d;
  logic       branch_d;
  logic       alu_op_d;
  logic [1:0] alu_control_d;
  logic [1:0] flag_w_d;
  logic       cmd_known;
  logic       pcs_d;

  always_comb begin
    reg_src_d    = 2'b00;
    imm_src_d    = 2'b00;
    alu_src_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_w_d      = 1'b0;
    mem_w_d      = 1'b0;
    branch_d     = 1'b0;
    alu_op_d     = 1'b0;
    unique case (Op)
      2'b00: begin
        alu_src_d = Funct[5];
        reg_w_d   = 1'b1;
        alu_op_d  = 1'b1;
      end
      2'b01: begin
        imm_src_d = 2'b01;
        alu_src_d = 1'b1;
        if (Funct[0]) begin
          mem_to_reg_d = 1'b1;
          reg_w_d      = 1'b1;
        end else begin
          reg_src_d = 2'b10;
          mem_w_d   = 1'b1;
        end
      end
      2'b10: begin
        reg_src_d = 2'b01;
        imm_src_d = 2'b10;
        alu_src_d = 1'b1;
        branch_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Unrecognized data-processing commands fall back to ADD and never touch flags.
  always_comb begin
    alu_control_d = 2'b00;
    cmd_known     = 1'b0;
    flag_w_d      = 2'b00;
    if (alu_op_d) begin
      cmd_known = 1'b1;
      case (Funct[4:1])
        4'b0100: alu_control_d = 2'b00;
        4'b0010: alu_control_d = 2'b01;
        4'b0000: alu_control_d = 2'b10;
        4'b1100: alu_control_d = 2'b11;
        default: begin
          alu_control_d = 2'b00;
          cmd_known     = 1'b0;
        end
      endcase
      if (cmd_known) begin
        flag_w_d[1] = Funct[0];
        flag_w_d[0] = Funct[0] & ~alu_control_d[1];
      end
    end
  end

  assign pcs_d = ((Rd == 4'b1111) & reg_w_d) | branch_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      FlagW      <= 2'b00;
      PCS        <= 1'b0;
      RegW       <= 1'b0;
      MemW       <= 1'b0;
      MemtoReg   <= 1'b0;
      ALUSrc     <= 1'b0;
      ImmSrc     <= 2'b00;
      RegSrc     <= 2'b00;
      ALUControl <= 2'b00;
    end else begin
      FlagW      <= flag_w_d;
      PCS        <= pcs_d;
      RegW       <= reg_w_d;
      MemW       <= mem_w_d;
      MemtoReg   <= mem_to_reg_d;
      ALUSrc     <= alu_src_d;
      ImmSrc     <= imm_src_d;
      RegSrc     <= reg_src_d;
      ALUControl <= alu_control_d;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: directed literal vectors, then randomized instructions
// checked every cycle against an instruction-class reference model.
module tb_decoder;

  localparam int W = 13;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       MemtoReg;
  logic       ALUSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  int vectors;
  int miscompares;
  logic [W-1:0] exp_q[$];

  decoder dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl}
  function automatic logic [W-1:0] dut_vec();
    return {FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl};
  endfunction

  // Reference model, written per instruction class.
  function automatic logic [W-1:0] model(input logic rst, input logic [1:0] op,
                                         input logic [5:0] fn, input logic [3:0] rd);
    bit is_dp, is_ldr, is_str, is_b, writes, s_bit;
    int cmd;
    logic [1:0] alu, flg, imm, rsrc;
    logic pcs;
    if (rst) return '0;
    is_dp  = (op == 2'd0);
    is_ldr = (op == 2'd1) && fn[0];
    is_str = (op == 2'd1) && !fn[0];
    is_b   = (op == 2'd2);
    writes = is_dp || is_ldr;
    s_bit  = fn[0];
    cmd    = int'(fn[4:1]);
    alu = 2'd0;
    flg = 2'd0;
    if (is_dp) begin
      if (cmd == 4)       alu = 2'd0;
      else if (cmd == 2)  alu = 2'd1;
      else if (cmd == 0)  alu = 2'd2;
      else if (cmd == 12) alu = 2'd3;
      if (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12)
        flg = {s_bit, s_bit && (cmd == 4 || cmd == 2)};
    end
    imm  = is_b ? 2'd2 : ((is_ldr || is_str) ? 2'd1 : 2'd0);
    rsrc = is_b ? 2'b01 : (is_str ? 2'b10 : 2'b00);
    pcs  = is_b || (writes && rd == 4'd15);
    return {flg, pcs, writes, is_str, is_ldr,
            (is_dp && fn[5]) || is_ldr || is_str || is_b, imm, rsrc, alu};
  endfunction

  // Scoreboard: the model of the inputs seen at each edge is due on that edge.
  always @(posedge clk) exp_q.push_back(model(reset, Op, Funct, Rd));

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (dut_vec() !== e) begin
        miscompares++;
        $display("FAIL model t=%0t op=%b funct=%b rd=%h got=%b exp=%b",
                 $time, Op, Funct, Rd, dut_vec(), e);
      end
    end
  end

  // driver: apply one vector, check against a hand-computed literal after the edge
  task automatic apply_lit(input string name, input logic rst, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd,
                           input logic [W-1:0] lit);
    @(negedge clk);
    reset = rst; Op = op; Funct = fn; Rd = rd;
    @(posedge clk);
    #1;
    vectors++;
    if (dut_vec() !== lit) begin
      miscompares++;
      $display("FAIL %s got=%b exp=%b", name, dut_vec(), lit);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'h0;
    repeat (2) @(posedge clk);
    apply_lit("reset_state", 1'b1, 2'b00, 6'b010000, 4'h0, 13'b00_0_0_0_0_0_00_00_00);
    apply_lit("add",      1'b0, 2'b00, 6'b010000, 4'h0, 13'b00_0_1_0_0_0_00_00_00);
    apply_lit("subs",     1'b0, 2'b00, 6'b000101, 4'h3, 13'b11_0_1_0_0_0_00_00_01);
    apply_lit("adds",     1'b0, 2'b00, 6'b001001, 4'h2, 13'b11_0_1_0_0_0_00_00_00);
    apply_lit("ands",     1'b0, 2'b00, 6'b000001, 4'h1, 13'b10_0_1_0_0_0_00_00_10);
    apply_lit("orr_imm",  1'b0, 2'b00, 6'b111000, 4'h4, 13'b00_0_1_0_0_1_00_00_11);
    apply_lit("bad_cmd",  1'b0, 2'b00, 6'b000111, 4'h5, 13'b00_0_1_0_0_0_00_00_00);
    apply_lit("ldr",      1'b0, 2'b01, 6'b000001, 4'h6, 13'b00_0_1_0_1_1_01_00_00);
    apply_lit("str",      1'b0, 2'b01, 6'b000000, 4'hf, 13'b00_0_0_1_0_1_01_10_00);
    apply_lit("branch",   1'b0, 2'b10, 6'b111111, 4'h0, 13'b00_1_0_0_0_1_10_01_00);
    apply_lit("dp_r15",   1'b0, 2'b00, 6'b010000, 4'hf, 13'b00_1_1_0_0_0_00_00_00);
    apply_lit("undef",    1'b0, 2'b11, 6'b111111, 4'hf, 13'b00_0_0_0_0_0_00_00_00);
    apply_lit("add_pre",  1'b0, 2'b00, 6'b010000, 4'h0, 13'b00_0_1_0_0_0_00_00_00);
    apply_lit("mid_reset",1'b1, 2'b00, 6'b010000, 4'h0, 13'b00_0_0_0_0_0_00_00_00);
    apply_lit("add_post", 1'b0, 2'b00, 6'b010000, 4'h0, 13'b00_0_1_0_0_0_00_00_00);

    // Random phase: cmd field biased toward recognized values, occasional reset.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 15) == 0);
      Op    = 2'($urandom_range(0, 3));
      Funct = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: Funct[4:1] = 4'b0100;
          1: Funct[4:1] = 4'b0010;
          2: Funct[4:1] = 4'b0000;
          default: Funct[4:1] = 4'b1100;
        endcase
      end
      Rd = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
